// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore FSM with a registered 4-bit state.
// Control outputs are combinational decodes of the current state, plus the
// zero and mem_ready inputs where a state needs them. While rst is high the
// write strobes and event pulses are forced low, so a reset never commits
// anything even though FETCH's strobes normally follow mem_ready.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] WBSrc,
  output logic       RegWrite,
  output logic       ExtSel,
  output logic       ASrc,
  output logic [1:0] BSrc,
  output logic [3:0] OpSel,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB  = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR  = 4'd5;
  localparam logic [STATE_W-1:0] S_EXEC   = 4'd6;
  localparam logic [STATE_W-1:0] S_ALUWB  = 4'd7;
  localparam logic [STATE_W-1:0] S_BRANCH = 4'd8;
  localparam logic [STATE_W-1:0] S_ADDIEX = 4'd9;
  localparam logic [STATE_W-1:0] S_ADDIWB = 4'd10;
  localparam logic [STATE_W-1:0] S_JUMP   = 4'd11;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;

  localparam logic [1:0] B_REG    = 2'b00;
  localparam logic [1:0] B_FOUR   = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic is_rtype;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_j;
  logic is_addi;
  logic op_legal;

  // Raw (ungated) versions of the strobes that reset must suppress
  logic pc_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic mem_write_raw;
  logic done_raw;
  logic illegal_raw;

  // Opcode classification shared by next-state and illegal decode
  always_comb begin
    is_rtype = (OpCode == OP_RTYPE);
    is_lw    = (OpCode == OP_LW);
    is_sw    = (OpCode == OP_SW);
    is_beq   = (OpCode == OP_BEQ);
    is_j     = (OpCode == OP_J);
    is_addi  = (OpCode == OP_ADDI);
    op_legal = is_rtype | is_lw | is_sw | is_beq | is_j | is_addi;
  end

  // State register; reset lands in FETCH without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw) begin
          state_d = S_MEMADR;
        end else if (is_rtype) begin
          state_d = S_EXEC;
        end else if (is_beq) begin
          state_d = S_BRANCH;
        end else if (is_j) begin
          state_d = S_JUMP;
        end else if (is_addi) begin
          state_d = S_ADDIEX;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (is_lw) begin
          state_d = S_MEMRD;
        end else if (is_sw) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Per-state control decode; everything not set by a state stays 0
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    done_raw      = 1'b0;
    illegal_raw   = 1'b0;
    PCSrc         = PC_ALU;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    RegDst        = 2'b00;
    WBSrc         = 2'b00;
    ExtSel        = 1'b0;
    ASrc          = 1'b0;
    BSrc          = B_REG;
    OpSel         = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        MemRead      = 1'b1;
        BSrc         = B_FOUR;
        pc_write_raw = mem_ready;
        ir_write_raw = mem_ready;
      end
      S_DECODE: begin
        BSrc        = B_IMM_SH;
        ExtSel      = 1'b1;
        illegal_raw = ~op_legal;
      end
      S_MEMADR: begin
        ASrc   = 1'b1;
        BSrc   = B_IMM;
        ExtSel = 1'b1;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        WBSrc         = 2'b01;
        done_raw      = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
        done_raw      = mem_ready;
      end
      S_EXEC: begin
        ASrc  = 1'b1;
        OpSel = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        RegDst        = 2'b01;
        done_raw      = 1'b1;
      end
      S_BRANCH: begin
        ASrc         = 1'b1;
        OpSel        = ALU_SUB;
        PCSrc        = PC_ALUOUT;
        pc_write_raw = zero;
        done_raw     = 1'b1;
      end
      S_ADDIEX: begin
        ASrc   = 1'b1;
        BSrc   = B_IMM;
        ExtSel = 1'b1;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      S_JUMP: begin
        PCSrc        = PC_JUMP;
        pc_write_raw = 1'b1;
        done_raw     = 1'b1;
      end
      default: begin
        MemRead = 1'b0;
      end
    endcase
  end

  // Reset suppresses every write strobe and event pulse
  always_comb begin
    PCWrite    = pc_write_raw  & ~rst;
    IRWrite    = ir_write_raw  & ~rst;
    RegWrite   = reg_write_raw & ~rst;
    MemWrite   = mem_write_raw & ~rst;
    instr_done = done_raw      & ~rst;
    illegal    = illegal_raw   & ~rst;
    state      = state_q;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OP_RTYPE, 6'h00, R-type opcode.
REQ-002 Parameter OP_LW, 6'h23, load-word opcode.
REQ-003 Parameter OP_SW, 6'h2B, store-word opcode.
REQ-004 Parameter OP_BEQ, 6'h04, branch-if-equal opcode.
REQ-005 Parameter OP_J, 6'h02, jump opcode.
REQ-006 Parameter OP_ADDI, 6'h08, add-immediate opcode.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 OpCode  in  6  opcode field of the instruction register.
REQ-010 zero  in  1  ALU zero flag.
REQ-011 mem_ready  in  1  memory has completed the current access this cycle.
REQ-012 PCWrite  out  1  PC load enable.
REQ-013 PCSrc  out  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-014 IorD  out  1  memory address: 0 PC, 1 ALUOut.
REQ-015 MemRead / MemWrite  out  1 each  memory strobes.
REQ-016 IRWrite  out  1  instruction register load enable.
REQ-017 RegDst  out  2  destination: 00 rt, 01 rd.
REQ-018 WBSrc  out  2  write-back source: 00 ALUOut, 01 memory data register.
REQ-019 RegWrite  out  1  register file write enable.
REQ-020 ExtSel  out  1  immediate extension: 1 sign, 0 zero.
REQ-021 ASrc  out  1  ALU A: 0 PC, 1 register A.
REQ-022 BSrc  out  2  ALU B: 00 register B, 01 constant 4, 10 extended immediate, 11 extended immediate shifted left 2.
REQ-023 OpSel  out  4  ALU op: 0000 ADD, 0001 SUB, 0010 decode from funct.
REQ-024 instr_done  out  1  one-cycle pulse in the final state of each legal instruction.
REQ-025 illegal  out  1  one-cycle pulse when DECODE sees an unlisted opcode.
REQ-026 state  out  4  current state encoding, for debug.

Function
REQ-027 Moore FSM with a registered 4-bit state; all outputs SHALL be combinational decodes of state plus zero/mem_ready only.
REQ-028 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; codes 12-15 SHALL go to FETCH with no strobes.
REQ-029 FETCH: MemRead=1, IorD=0, ASrc=0, BSrc=01, OpSel=ADD, PCSrc=00, PCWrite=IRWrite=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-030 DECODE: ASrc=0, BSrc=11, OpSel=ADD, ExtSel=1; next by OpCode: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX, other->FETCH with illegal=1.
REQ-031 MEMADR: ASrc=1, BSrc=10, ExtSel=1, OpSel=ADD; LW->MEMRD, SW->MEMWR.
REQ-032 MEMRD: MemRead=1, IorD=1; hold while mem_ready=0; then MEMWB.
REQ-033 MEMWB: RegWrite=1, RegDst=00, WBSrc=01, instr_done=1; then FETCH.
REQ-034 MEMWR: MemWrite=1, IorD=1; hold while mem_ready=0; instr_done=mem_ready; then FETCH.
REQ-035 EXEC: ASrc=1, BSrc=00, OpSel=0010; then ALUWB (RegWrite=1, RegDst=01, WBSrc=00, instr_done=1), then FETCH.
REQ-036 ADDIEX: ASrc=1, BSrc=10, ExtSel=1, OpSel=ADD; then ADDIWB (RegWrite=1, RegDst=00, WBSrc=00, instr_done=1), then FETCH.
REQ-037 BRANCH: ASrc=1, BSrc=00, OpSel=SUB, PCSrc=01, PCWrite=zero, instr_done=1; then FETCH.
REQ-038 JUMP: PCSrc=10, PCWrite=1, instr_done=1; then FETCH.
REQ-039 Unlisted outputs in any state SHALL be 0; at most one of MemRead/MemWrite SHALL be high in any cycle.
REQ-040 Zero-wait latencies (cycles FETCH to FETCH): LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.

Reset
REQ-041 rst=1 SHALL force state to FETCH immediately, independent of clk.
REQ-042 While rst=1 all write strobes (PCWrite, IRWrite, RegWrite, MemWrite) and instr_done/illegal SHALL be 0, regardless of mem_ready.
REQ-043 Reset mid-instruction SHALL abandon it; first rising edge after rst deasserts evaluates FETCH.

Verification
REQ-044 Reset with mem_ready=1 -> state=0, all strobes 0; release -> PCWrite=IRWrite=1 next cycle.
REQ-045 LW (6'h23), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1, WBSrc=01 only in state 4; instr_done once.
REQ-046 BEQ with zero=1 then zero=0 -> PCWrite=1 in BRANCH for first, 0 for second; both 3 cycles.
REQ-047 SW with mem_ready low 2 cycles in MEMWR -> MemWrite held 3 cycles, instr_done only on ready cycle, 6 total cycles.
REQ-048 OpCode 6'h3F in DECODE -> illegal=1 one cycle, next state 0, no write strobe.
REQ-049 rst asserted mid-MEMRD -> state=0 asynchronously, MemRead drops to FETCH value, no RegWrite.
